cast_output_port_stage: RTL

Per-output-port switch stage that sits directly downstream of `cast_input_port_stage`.
- Each cycle, a round-robin arbiter picks one flit among all input-port VCs whose `req_port` bit selects this output.
- Per-downstream-VC credit counters sized to the next router's 4-deep input FIFO gate each request.
- The granted flit is registered onto the link.
- The grant is returned combinationally as that VC's `ready_i`, so the input stage's `fire`/`last` sequencing (unicast-based multicast) operates unchanged.

---
 rtl/cast_output_port_stage.sv | 88 ++++++++
 1 files changed

// File: rtl/cast_output_port_stage.sv
// cast_output_port_stage: round-robin output-port arbiter with per-VC credit gating and a registered link
`ifndef VN
`define VN 2
`endif
`ifndef DW
`define DW 16
`endif
module cast_output_port_stage #(
  parameter int NREQ = 8,
  parameter int CRED = 4,
  parameter int CW = $clog2(CRED + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_i,
  input  logic [`DW-1:0]     data_i [NREQ],
  input  logic [`VN-1:0]     ovc_i [NREQ],
  output logic [NREQ-1:0]    grant_o,
  output logic [`DW-1:0]     data_o,
  output logic [`VN-1:0]     vc_o,
  output logic               valid_o,
  input  logic [`VN-1:0]     credit_i,
  output logic               err_o
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [CW-1:0]   cnt [`VN];
  logic [`VN-1:0]  nz;
  logic [`VN-1:0]  dec;
  logic [NREQ-1:0] elig;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic            any;
  logic            gnt;
  int              j;
  // a requester is eligible only if its downstream VC still has a credit
  always_comb begin
    for (int v = 0; v < `VN; v++) nz[v] = cnt[v] != '0;
    for (int r = 0; r < NREQ; r++) elig[r] = req_i[r] & |(ovc_i[r] & nz);
  end
  // round-robin pick: scan backwards so the first eligible index at or after ptr wins last
  always_comb begin
    any = 1'b0;
    win = '0;
    j = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NREQ;
      if (elig[PW'(j)]) begin
        any = 1'b1;
        win = PW'(j);
      end
    end
  end
  // grant is suppressed in reset so the input stage never consumes a flit that would be dropped
  always_comb begin
    gnt = any & ~rst;
    grant_o = gnt ? {{(NREQ-1){1'b0}}, 1'b1} << win : '0;
    dec = gnt ? ovc_i[win] : '0;
  end
  // link register and round-robin pointer advance on each grant
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      data_o <= '0;
      vc_o <= '0;
      ptr <= '0;
    end else begin
      valid_o <= gnt;
      if (gnt) begin
        data_o <= data_i[win];
        vc_o <= ovc_i[win];
        ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end
  // per-VC credit counters; a return at full count is an overflow and is flagged stickily
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
      for (int v = 0; v < `VN; v++) cnt[v] <= CW'(CRED);
    end else begin
      for (int v = 0; v < `VN; v++)
        if (credit_i[v] && !dec[v]) begin
          if (cnt[v] == CW'(CRED)) err_o <= 1'b1;
          else cnt[v] <= cnt[v] + 1'b1;
        end else if (dec[v] && !credit_i[v]) cnt[v] <= cnt[v] - 1'b1;
    end
  end
endmodule
